// File: rtl/operand_fetch_pkg.sv
// Shared constants for the register-read stage and the register file.
package operand_fetch_pkg;

  localparam int INDEX_BITS = 4;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 2 ** INDEX_BITS;

endpackage : operand_fetch_pkg

// File: rtl/operand_scoreboard.sv
// Busy scoreboard: one pending-write bit per architectural register.
// A set and a clear naming the same register in one cycle leave it busy,
// because the newly issued writer is younger than the one retiring.
module operand_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int IDX_W  = INDEX_BITS,
  parameter int N_REGS = NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_index,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_index,
  input  logic [IDX_W-1:0]  rs0_index,
  input  logic [IDX_W-1:0]  rs1_index,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rs0_busy,
  output logic              rs1_busy,
  output logic              rd_busy,
  output logic [N_REGS-1:0] busy_mask
);

  logic [N_REGS-1:0] busy_reg;

  generate
    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_busy
      // Per-register busy bit: set beats clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          busy_reg[gi] <= 1'b0;
        end else if (set_en && (set_index == IDX_W'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (clr_en && (clr_index == IDX_W'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign rs0_busy  = busy_reg[rs0_index];
  assign rs1_busy  = busy_reg[rs1_index];
  assign rd_busy   = busy_reg[rd_index];
  assign busy_mask = busy_reg;

endmodule : operand_scoreboard

// File: rtl/operand_fetch.sv
// Register-read stage: reads both sources, bypasses same-cycle writeback,
// blocks issue on RAW/WAW hazards and holds operands in a one-entry skid-free
// output register toward execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int INDEX_BITS_P = INDEX_BITS,
  parameter int DATA_WIDTH_P = DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [INDEX_BITS_P-1:0]   inRs0,
  input  logic [INDEX_BITS_P-1:0]   inRs1,
  input  logic                      inUseRs0,
  input  logic                      inUseRs1,
  input  logic [INDEX_BITS_P-1:0]   inRd,
  input  logic                      inRdWrEn,
  output logic [INDEX_BITS_P-1:0]   regFileRd0Index,
  output logic [INDEX_BITS_P-1:0]   regFileRd1Index,
  input  logic [DATA_WIDTH_P-1:0]   rfData0,
  input  logic [DATA_WIDTH_P-1:0]   rfData1,
  input  logic                      wbEn,
  input  logic [INDEX_BITS_P-1:0]   wbIndex,
  input  logic [DATA_WIDTH_P-1:0]   wbData,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_WIDTH_P-1:0]   outOp0,
  output logic [DATA_WIDTH_P-1:0]   outOp1,
  output logic [INDEX_BITS_P-1:0]   outRd,
  output logic                      outRdWrEn,
  output logic [2**INDEX_BITS_P-1:0] busyMask
);

  logic rs0_busy, rs1_busy, rd_busy;
  logic wb_hit_rs0, wb_hit_rs1, wb_hit_rd;
  logic src_stall, waw_stall, issue;
  logic [DATA_WIDTH_P-1:0] op0_next, op1_next;

  logic                    out_valid_reg;
  logic [DATA_WIDTH_P-1:0] out_op0_reg, out_op1_reg;
  logic [INDEX_BITS_P-1:0] out_rd_reg;
  logic                    out_rd_wr_en_reg;

  assign regFileRd0Index = inRs0;
  assign regFileRd1Index = inRs1;

  operand_scoreboard #(
    .IDX_W  (INDEX_BITS_P),
    .N_REGS (2 ** INDEX_BITS_P)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (issue && inRdWrEn),
    .set_index (inRd),
    .clr_en    (wbEn),
    .clr_index (wbIndex),
    .rs0_index (inRs0),
    .rs1_index (inRs1),
    .rd_index  (inRd),
    .rs0_busy  (rs0_busy),
    .rs1_busy  (rs1_busy),
    .rd_busy   (rd_busy),
    .busy_mask (busyMask)
  );

  // A write landing this cycle resolves the hazard it would otherwise cause.
  assign wb_hit_rs0 = wbEn && (wbIndex == inRs0);
  assign wb_hit_rs1 = wbEn && (wbIndex == inRs1);
  assign wb_hit_rd  = wbEn && (wbIndex == inRd);

  assign src_stall = (inUseRs0 && rs0_busy && !wb_hit_rs0) ||
                     (inUseRs1 && rs1_busy && !wb_hit_rs1);
  assign waw_stall = inRdWrEn && rd_busy && !wb_hit_rd;
  assign inReady   = (!out_valid_reg || outReady) && !src_stall && !waw_stall;
  assign issue     = inValid && inReady;

  // Operand select: unused source reads as zero, bypass beats register file.
  always_comb begin
    op0_next = '0;
    op1_next = '0;
    if (inUseRs0) op0_next = wb_hit_rs0 ? wbData : rfData0;
    if (inUseRs1) op1_next = wb_hit_rs1 ? wbData : rfData1;
  end

  // Output register: load on issue, drain when execute takes it, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg    <= 1'b0;
      out_op0_reg      <= '0;
      out_op1_reg      <= '0;
      out_rd_reg       <= '0;
      out_rd_wr_en_reg <= 1'b0;
    end else if (issue) begin
      out_valid_reg    <= 1'b1;
      out_op0_reg      <= op0_next;
      out_op1_reg      <= op1_next;
      out_rd_reg       <= inRd;
      out_rd_wr_en_reg <= inRdWrEn;
    end else if (outReady) begin
      out_valid_reg    <= 1'b0;
    end
  end

  assign outValid  = out_valid_reg;
  assign outOp0    = out_op0_reg;
  assign outOp1    = out_op1_reg;
  assign outRd     = out_rd_reg;
  assign outRdWrEn = out_rd_wr_en_reg;

endmodule : operand_fetch

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hazards, bypass, backpressure, reset.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, inReady;
  logic [3:0]  inRs0, inRs1, inRd;
  logic        inUseRs0, inUseRs1, inRdWrEn;
  logic [3:0]  regFileRd0Index, regFileRd1Index;
  logic [31:0] rfData0, rfData1;
  logic        wbEn;
  logic [3:0]  wbIndex;
  logic [31:0] wbData;
  logic        outValid, outReady;
  logic [31:0] outOp0, outOp1;
  logic [3:0]  outRd;
  logic        outRdWrEn;
  logic [15:0] busyMask;

  logic [31:0] rf [16];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Register file model: combinational read, write on writeback.
  assign rfData0 = rf[regFileRd0Index];
  assign rfData1 = rf[regFileRd1Index];
  always @(posedge clk) if (wbEn) rf[wbIndex] <= wbData;

  operand_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .inValid         (inValid),
    .inReady         (inReady),
    .inRs0           (inRs0),
    .inRs1           (inRs1),
    .inUseRs0        (inUseRs0),
    .inUseRs1        (inUseRs1),
    .inRd            (inRd),
    .inRdWrEn        (inRdWrEn),
    .regFileRd0Index (regFileRd0Index),
    .regFileRd1Index (regFileRd1Index),
    .rfData0         (rfData0),
    .rfData1         (rfData1),
    .wbEn            (wbEn),
    .wbIndex         (wbIndex),
    .wbData          (wbData),
    .outValid        (outValid),
    .outReady        (outReady),
    .outOp0          (outOp0),
    .outOp1          (outOp1),
    .outRd           (outRd),
    .outRdWrEn       (outRdWrEn),
    .busyMask        (busyMask)
  );

  task automatic drive(input logic v, input logic [3:0] rs0, input logic u0,
                       input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rd, input logic we);
    inValid = v; inRs0 = rs0; inUseRs0 = u0; inRs1 = rs1; inUseRs1 = u1;
    inRd = rd; inRdWrEn = we;
  endtask

  task automatic wb(input logic en, input logic [3:0] idx, input logic [31:0] d);
    wbEn = en; wbIndex = idx; wbData = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; outReady = 1'b1;
    drive(0, 4'd1, 0, 4'd9, 0, 4'd0, 0);
    wb(0, 4'd0, 32'h0);
    step(); step();
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", outValid); end
    n_cmp++; if (outOp0 !== 32'h0 || outOp1 !== 32'h0) begin n_fail++; $display("FAIL reset_ops got %h/%h want 0/0", outOp0, outOp1); end
    n_cmp++; if (outRd !== 4'd0 || outRdWrEn !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %0d/%0b want 0/0", outRd, outRdWrEn); end
    n_cmp++; if (busyMask !== 16'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0000", busyMask); end
    n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", inReady); end
    n_cmp++; if (regFileRd0Index !== 4'd1 || regFileRd1Index !== 4'd9) begin n_fail++; $display("FAIL rf_index got %0d/%0d want 1/9", regFileRd0Index, regFileRd1Index); end
    $display("reset: valid=%0b busy=%h ready=%0b", outValid, busyMask, inReady);
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive(1, 4'd2, 1, 4'd3, 1, 4'd5, 1); #1;
    n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %0b want 1", inReady); end
    step();
    n_cmp++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", outValid); end
    n_cmp++; if (outOp0 !== 32'h11 || outOp1 !== 32'h22) begin n_fail++; $display("FAIL basic_ops got %h/%h want 11/22", outOp0, outOp1); end
    n_cmp++; if (outRd !== 4'd5 || outRdWrEn !== 1'b1) begin n_fail++; $display("FAIL basic_rd got %0d/%0b want 5/1", outRd, outRdWrEn); end
    n_cmp++; if (busyMask !== 16'h0020) begin n_fail++; $display("FAIL basic_busy got %h want 0020", busyMask); end
    $display("basic: op0=%h op1=%h rd=%0d busy=%h", outOp0, outOp1, outRd, busyMask);
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive(1, 4'd5, 1, 4'd0, 0, 4'd0, 0); #1;
    n_cmp++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL raw_stall got %0b want 0", inReady); end
    step();
    n_cmp++; if (outValid !== 1'b0 || busyMask !== 16'h0020) begin n_fail++; $display("FAIL raw_hold got v=%0b busy=%h want v=0 busy=0020", outValid, busyMask); end
    @(negedge clk);
    wb(1, 4'd5, 32'hDEAD); #1;
    n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL bypass_ready got %0b want 1", inReady); end
    step();
    n_cmp++; if (outValid !== 1'b1 || outOp0 !== 32'hDEAD || outOp1 !== 32'h0) begin n_fail++; $display("FAIL bypass_ops got v=%0b %h/%h want v=1 dead/0", outValid, outOp0, outOp1); end
    n_cmp++; if (busyMask !== 16'h0000) begin n_fail++; $display("FAIL bypass_busy got %h want 0000", busyMask); end
    @(negedge clk);
    drive(0, 4'd0, 0, 4'd0, 0, 4'd0, 0); wb(0, 4'd0, 32'h0);
    $display("bypass: op0=%h busy=%h", outOp0, busyMask);
  endtask

  task automatic test_waw();
    @(negedge clk);
    drive(1, 4'd0, 0, 4'd0, 0, 4'd7, 1);
    step();
    n_cmp++; if (busyMask !== 16'h0080) begin n_fail++; $display("FAIL waw_set got %h want 0080", busyMask); end
    @(negedge clk); #1;
    n_cmp++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL waw_stall got %0b want 0", inReady); end
    step();
    n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL waw_bubble got %0b want 0", outValid); end
    @(negedge clk);
    wb(1, 4'd7, 32'h77); #1;
    n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL waw_release got %0b want 1", inReady); end
    step();
    n_cmp++; if (outValid !== 1'b1 || outRd !== 4'd7 || busyMask !== 16'h0080) begin n_fail++; $display("FAIL waw_setwins got v=%0b rd=%0d busy=%h want v=1 rd=7 busy=0080", outValid, outRd, busyMask); end
    @(negedge clk);
    drive(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
    step();
    @(negedge clk); wb(0, 4'd0, 32'h0);
    n_cmp++; if (busyMask !== 16'h0000 || outValid !== 1'b0) begin n_fail++; $display("FAIL waw_drain got busy=%h v=%0b want 0000/0", busyMask, outValid); end
    $display("waw: busy=%h", busyMask);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    outReady = 1'b0;
    drive(1, 4'd2, 1, 4'd3, 1, 4'd0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 4'd3, 1, 4'd2, 1, 4'd0, 0); #1;
      n_cmp++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %0b want 0", i, inReady); end
      step();
      n_cmp++; if (outValid !== 1'b1 || outOp0 !== 32'h11 || outOp1 !== 32'h22) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%0b %h/%h want v=1 11/22", i, outValid, outOp0, outOp1); end
    end
    @(negedge clk);
    outReady = 1'b1; #1;
    n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL bp_release got %0b want 1", inReady); end
    step();
    n_cmp++; if (outValid !== 1'b1 || outOp0 !== 32'h22 || outOp1 !== 32'h11) begin n_fail++; $display("FAIL bp_load got v=%0b %h/%h want v=1 22/11", outValid, outOp0, outOp1); end
    @(negedge clk);
    drive(1, 4'd2, 1, 4'd2, 1, 4'd0, 0);
    step();
    n_cmp++; if (outValid !== 1'b1 || outOp0 !== 32'h11 || outOp1 !== 32'h11) begin n_fail++; $display("FAIL back_to_back got v=%0b %h/%h want v=1 11/11", outValid, outOp0, outOp1); end
    $display("backpressure: op0=%h op1=%h", outOp0, outOp1);
  endtask

  task automatic test_unused();
    @(negedge clk);
    drive(1, 4'd0, 0, 4'd0, 0, 4'd4, 1);
    step();
    @(negedge clk);
    drive(1, 4'd4, 0, 4'd4, 0, 4'd0, 0);
    wb(1, 4'd9, 32'h99); #1;
    n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL unused_ready got %0b want 1", inReady); end
    step();
    n_cmp++; if (outValid !== 1'b1 || outOp0 !== 32'h0 || outOp1 !== 32'h0) begin n_fail++; $display("FAIL unused_ops got v=%0b %h/%h want v=1 0/0", outValid, outOp0, outOp1); end
    n_cmp++; if (busyMask !== 16'h0010) begin n_fail++; $display("FAIL unused_busy got %h want 0010", busyMask); end
    @(negedge clk); wb(0, 4'd0, 32'h0);
    $display("unused: op0=%h op1=%h busy=%h", outOp0, outOp1, busyMask);
  endtask

  task automatic test_reset_mid();
    drive(1, 4'd3, 1, 4'd0, 0, 4'd5, 1); step();
    @(negedge clk); drive(1, 4'd3, 1, 4'd0, 0, 4'd6, 1); step();
    @(negedge clk); drive(1, 4'd3, 1, 4'd0, 0, 4'd7, 1); step();
    n_cmp++; if (busyMask !== 16'h00F0 || outValid !== 1'b1 || outOp0 !== 32'h22) begin n_fail++; $display("FAIL mid_setup got busy=%h v=%0b op0=%h want 00f0/1/22", busyMask, outValid, outOp0); end
    @(negedge clk);
    drive(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
    reset = 1'b1;
    step();
    n_cmp++; if (busyMask !== 16'h0 || outValid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got busy=%h v=%0b want 0000/0", busyMask, outValid); end
    n_cmp++; if (outOp0 !== 32'h0 || outOp1 !== 32'h0 || outRd !== 4'd0 || outRdWrEn !== 1'b0) begin n_fail++; $display("FAIL mid_payload got %h/%h rd=%0d we=%0b want 0", outOp0, outOp1, outRd, outRdWrEn); end
    @(negedge clk); reset = 1'b0;
    $display("reset_mid: busy=%h valid=%0b", busyMask, outValid);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
    rf[2] = 32'h11;
    rf[3] = 32'h22;
    rf[5] = 32'h55;
    test_reset();
    test_basic();
    test_bypass();
    test_waw();
    test_backpressure();
    test_unused();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_operand_fetch

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage sitting between decode and execute. Drives the register file's two combinational read indices and captures both operands into a one-entry output register. Snoops the register file write port to bypass same-cycle writeback data. Keeps a 16-entry busy scoreboard so no instruction issues while a source or destination register still has an outstanding write.

## Interface
Parameters:
- INDEX_BITS, 4, register index width (16 registers)
- DATA_WIDTH, 32, operand width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- inValid  in  1  decoded instruction present
- inReady  out  1  stage accepts instruction this cycle
- inRs0, inRs1  in  INDEX_BITS  source indices
- inUseRs0, inUseRs1  in  1  source actually read
- inRd  in  INDEX_BITS  destination index
- inRdWrEn  in  1  instruction will write inRd
- regFileRd0Index, regFileRd1Index  out  INDEX_BITS  register file read addresses
- rfData0, rfData1  in  DATA_WIDTH  register file read data (combinational)
- wbEn  in  1  writeback this cycle (same signal as register file write enable)
- wbIndex  in  INDEX_BITS  writeback index
- wbData  in  DATA_WIDTH  writeback data
- outValid  out  1  operands valid to execute
- outReady  in  1  execute accepts
- outOp0, outOp1  out  DATA_WIDTH  captured operands
- outRd  out  INDEX_BITS  captured destination
- outRdWrEn  out  1  captured write flag
- busyMask  out  16  scoreboard state, bit i = register i pending

## Operation
- regFileRd0Index = inRs0, regFileRd1Index = inRs1, combinational, always.
- wbHit(r) = wbEn && wbIndex == r.
- srcStall = (inUseRs0 && busy[inRs0] && !wbHit(inRs0)) || (inUseRs1 && busy[inRs1] && !wbHit(inRs1)).
- wawStall = inRdWrEn && busy[inRd] && !wbHit(inRd).
- inReady = (!outValid || outReady) && !srcStall && !wawStall; independent of inValid.
- issue = inValid && inReady.
- Operand select per source: unused -> 0; wbHit -> wbData; else rfData.
- On issue: outOp0/1, outRd, outRdWrEn loaded; outValid <= 1.
- No issue and outReady: outValid <= 0; payload holds.
- Scoreboard next: busy[wbIndex] cleared if wbEn; busy[inRd] set if issue && inRdWrEn; set wins when both name the same index.
- wbEn to a non-busy register: no effect on scoreboard.
- Any index may be used, including 0; no hardwired zero register.

## Timing
- Reset: outValid=0, outOp0=0, outOp1=0, outRd=0, outRdWrEn=0, busyMask=0; inReady follows reset state (1 if no hazard).
- Reset asserted mid-operation: pending busy bits and held output discarded next edge.
- Latency: issue at edge N -> outValid high after edge N, held until outReady sampled high.
- Full throughput: outValid && outReady && issue in same cycle -> back-to-back, no bubble.
- Backpressure: outValid && !outReady -> inReady=0, payload stable.
- Bypass zero-latency: source written at the same edge it is read issues that cycle with wbData.
- busyMask reflects registered state only; does not include same-cycle set/clear.

## Structure
- Shared package: INDEX_BITS, DATA_WIDTH, NUM_REGS (=2**INDEX_BITS) constants, shared with the register file.
- Sub-module operand_scoreboard: NUM_REGS busy bits, set/clear ports, three lookup ports returning busy for rs0/rs1/rd; set-over-clear priority inside.
- Top holds hazard logic, bypass muxes, output register.

## Test plan
- Reset then issue rs0=2, rs1=3 (RF r2=0x11, r3=0x22), rdWrEn rd=5 -> next cycle outValid=1, outOp0=0x11, outOp1=0x22, outRd=5, busyMask=0x0020.
- With r5 busy, present inUseRs0 rs0=5 -> inReady=0; on wbEn wbIndex=5 wbData=0xDEAD same cycle -> issue, outOp0=0xDEAD, busyMask bit5 cleared.
- WAW: r7 busy, instruction rdWrEn rd=7, no sources -> stalls until wbIndex=7; issues that cycle, bit7 remains 1 (set wins).
- Hold outReady=0 for 3 cycles with outValid=1 -> inReady=0, outOp0/outOp1 unchanged; release -> next instruction loads, no bubble.
- Unused sources: inUseRs0=inUseRs1=0, rs0=rs1=4 busy -> issues, outOp0=outOp1=0.
- Assert reset with busyMask=0x00F0, outValid=1 -> after edge busyMask=0, outValid=0, all payload 0.
